adder_stream_arbiter: RTL and testbench
=======================================

# adder_stream_arbiter

Round-robin, packet-granular arbiter that shares the adder's single AXI-Stream slave interface among NUM_REQ producer streams. It sits between the producers and the adder, locks the grant for a whole transaction (first beat through tlast), and re-arbitrates only at packet boundaries. A registered output slice drives the adder, so the adder always sees an uninterleaved, glitch-free stream.

## Interface
- NUM_REQ, 4, number of requesting producer streams (2..16).
- DATAW, `AXIS_MAX_DATAW, beat width. Taken from static_params.vh.
- CNTW, 16, width of the completed-packet counter.
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- s_tvalid  in  NUM_REQ  per-requester beat valid.
- s_tlast  in  NUM_REQ  per-requester last beat of a transaction.
- s_tdata  in  NUM_REQ*DATAW  requester i occupies bits [i*DATAW +: DATAW].
- s_tready  out  NUM_REQ  per-requester ready. At most one bit is set at a time.
- m_tvalid  out  1  beat valid toward the adder.
- m_tlast  out  1  last beat toward the adder.
- m_tdata  out  DATAW  beat data toward the adder.
- m_tready  in  1  adder ready.
- grant_id  out  $clog2(NUM_REQ)  index of the currently or most recently granted requester.
- busy  out  1  high while in STREAM.
- pkt_count  out  CNTW  number of packets forwarded (output tlast handshakes). Wraps modulo 2^CNTW.

## Operation
- The FSM has two states: IDLE and STREAM.
- IDLE
  - If any bit of s_tvalid is set, pick the first set bit searching upward from (last_grant+1) mod NUM_REQ.
  - Register the pick in grant_id and last_grant, then go to STREAM.
  - Requests are judged only on s_tvalid; tlast is irrelevant during arbitration.
- STREAM
  - s_tready[grant_id] = !m_tvalid || m_tready. All other s_tready bits are 0.
  - On an input handshake:
    - load the output slice with the granted requester's tdata and tlast;
    - set m_tvalid.
  - On an input handshake with tlast set, go to IDLE.
- Output slice
  - Output handshake (m_tvalid && m_tready) with no new load: clear m_tvalid.
  - Load and drain in the same cycle: replace the slice contents; m_tvalid stays 1.
  - While m_tvalid && !m_tready: m_tdata and m_tlast hold stable.
- pkt_count increments on every output handshake with m_tlast = 1.
- Boundary conditions
  - All requesters valid at once after reset: grant order is 0, 1, ..., NUM_REQ-1, then wraps.
  - Granted requester drops tvalid mid-packet: the grant is held indefinitely. There is no timeout and no preemption.
  - A non-granted requester asserting tvalid is ignored. Its data must not reach m_tdata.
  - Single-beat packet (tlast on the first beat): STREAM lasts exactly one handshake.
  - Only one requester active: it is re-granted each time, because the search wraps back to it.
  - pkt_count wraps from 2^CNTW-1 to 0.
- Reset (including mid-packet): every output and all state take reset values on the next edge. The in-flight beat in the slice is discarded.
- Reset values:
  - state IDLE;
  - m_tvalid 0, m_tlast 0, m_tdata 0;
  - s_tready all 0;
  - grant_id 0, busy 0, pkt_count 0;
  - last_grant NUM_REQ-1, so requester 0 has first priority.

## Timing
- Arbitration
  - Requests sampled in IDLE at edge k: grant_id and busy are valid after edge k.
  - s_tready[g] can be high in the cycle after edge k.
  - The first beat is accepted at edge k+1 at the earliest, and m_tvalid rises after edge k+1.
- Latency: input handshake to m_tvalid is exactly 1 cycle.
- Throughput: 1 beat/cycle within a packet while m_tready stays high.
- Packet turnaround: tlast accepted at edge j leads to re-arbitration at edge j+1. The next first beat is accepted at edge j+2 at the earliest, giving one idle input cycle between packets.
- Backpressure: m_tready low with the slice full drives s_tready low in the same cycle (combinational). There is no slice overflow.

## Structure
- static_params.vh holds the shared constants AXIS_MAX_DATAW and DATAW and the FSM state encodings (ARB_IDLE, ARB_STREAM). It is included by the arbiter and by the adder.
- One sub-module, rr_pick: combinational round-robin picker. Inputs are the request vector and last_grant; outputs are the winner index and an any-request flag. It is reused by other shared-slave arbiters.
- The output slice is inline in adder_stream_arbiter; it needs no separate module.

## Test plan
- After reset, all 4 requesters send 1-beat packets with data 10, 20, 30, 40 and m_tready held at 1:
  - adder receives 10, 20, 30, 40 in that order;
  - pkt_count = 4;
  - exactly one idle cycle between beats on the input side.
- Requester 2 sends a 3-beat packet (5, 6, 7) while requester 1 requests continuously:
  - output is 5, 6, 7 with no requester-1 beat interleaved;
  - m_tlast is set only on 7;
  - requester 1 is granted next.
- m_tready is toggled randomly during a 4-beat packet (1, 2, 3, 4):
  - m_tdata is stable while stalled;
  - no beat is dropped or duplicated;
  - the sum at the adder is 10.
- Granted requester 0 drops tvalid for 5 cycles mid-packet while requester 3 is valid:
  - grant_id stays 0;
  - s_tready[3] stays 0 throughout.
- rst asserted while m_tvalid = 1 mid-packet:
  - after the next edge, m_tvalid = 0, s_tready = 0, pkt_count = 0;
  - the next arbitration favours requester 0.
- Run with CNTW = 2 and 5 packets: pkt_count reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/adder_stream_arbiter_pkg.sv
// Shared constants for the adder stream arbiter: beat width and FSM state encodings.
package adder_stream_arbiter_pkg;
    localparam int AXIS_MAX_DATAW = 32;

    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_STREAM = 1'b1;
endpackage

// File: rtl/adder_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_grant+1, wrapping.
// Zero latency; any_req flags that pick is meaningful.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic [IDW-1:0] pick,
    output logic           any_req
);
    logic [IDW-1:0] cand;

    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDW'((int'(last_grant) + k) % N);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end
endmodule

// File: rtl/adder_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream slave among NUM_REQ producers.
// Input handshake to m_tvalid is 1 cycle; s_tready of the granted stream drops combinationally when the slice is stalled.
module adder_stream_arbiter
    import adder_stream_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATAW   = AXIS_MAX_DATAW,
    parameter int CNTW    = 16,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       s_tvalid,
    input  logic [NUM_REQ-1:0]       s_tlast,
    input  logic [NUM_REQ*DATAW-1:0] s_tdata,
    output logic [NUM_REQ-1:0]       s_tready,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    output logic [DATAW-1:0]         m_tdata,
    input  logic                     m_tready,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy,
    output logic [CNTW-1:0]          pkt_count
);
    logic [0:0]       state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   pick;
    logic             any_req;
    logic             sel_vld;
    logic             sel_last;
    logic [DATAW-1:0] sel_dat;
    logic             slice_open;
    logic             in_hs;
    logic             out_hs;

    rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
        .req        (s_tvalid),
        .last_grant (last_grant),
        .pick       (pick),
        .any_req    (any_req)
    );

    assign sel_vld    = s_tvalid[grant_id];
    assign sel_last   = s_tlast[grant_id];
    assign sel_dat    = s_tdata[grant_id*DATAW +: DATAW];
    assign slice_open = !m_tvalid || m_tready;
    assign in_hs      = (state == ARB_STREAM) && sel_vld && slice_open;
    assign out_hs     = m_tvalid && m_tready;
    assign busy       = (state == ARB_STREAM);

    // Only the locked requester ever sees ready, so other streams cannot leak into the slice.
    always_comb begin
        s_tready = '0;
        if (state == ARB_STREAM) begin
            s_tready[grant_id] = slice_open;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant_id   <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_tdata    <= '0;
            pkt_count  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_id   <= pick;
                        last_grant <= pick;
                        state      <= ARB_STREAM;
                    end
                end
                default: begin
                    if (in_hs && sel_last) begin
                        state <= ARB_IDLE;
                    end
                end
            endcase

            if (in_hs) begin
                m_tvalid <= 1'b1;
                m_tdata  <= sel_dat;
                m_tlast  <= sel_last;
            end else if (out_hs) begin
                m_tvalid <= 1'b0;
            end

            if (out_hs && m_tlast) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adder_stream_arbiter.sv
// Bench for adder_stream_arbiter: directed steps plus randomized packets against a queue-based arbitration model.
module tb_adder_stream_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATAW   = 32;
    localparam int IDW     = 2;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic             last;
    } beat_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       s_tvalid = '0;
    logic [NUM_REQ-1:0]       s_tlast = '0;
    logic [NUM_REQ*DATAW-1:0] s_tdata = '0;
    logic [NUM_REQ-1:0]       s_tready, s_tready2;
    logic                     m_tvalid, m_tvalid2;
    logic                     m_tlast, m_tlast2;
    logic [DATAW-1:0]         m_tdata, m_tdata2;
    logic                     m_tready = 1'b1;
    logic [IDW-1:0]           grant_id, grant_id2;
    logic                     busy, busy2;
    logic [15:0]              pkt_count;
    logic [1:0]               pkt_count2;

    adder_stream_arbiter #(.NUM_REQ(NUM_REQ), .DATAW(DATAW), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tdata(s_tdata),
        .s_tready(s_tready), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdata(m_tdata),
        .m_tready(m_tready), .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count)
    );

    // Narrow-counter copy on the same inputs, to see the count wrap quickly.
    adder_stream_arbiter #(.NUM_REQ(NUM_REQ), .DATAW(DATAW), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tdata(s_tdata),
        .s_tready(s_tready2), .m_tvalid(m_tvalid2), .m_tlast(m_tlast2), .m_tdata(m_tdata2),
        .m_tready(m_tready), .grant_id(grant_id2), .busy(busy2), .pkt_count(pkt_count2)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t drv_q[NUM_REQ][$];
    beat_t mdl_q[NUM_REQ][$];
    beat_t exp_q[$];
    bit    first_beat[NUM_REQ];
    int    mdl_last = NUM_REQ - 1;
    int    mdl_cnt  = 0;
    int    cycle    = 0;
    int    last_tlast_cyc = -1;
    bit    gap_chk  = 0;
    bit    rdy_rand = 0;
    bit    gap_en   = 0;
    int    hold0    = 0;
    longint out_sum = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic add_pkt(input int r, input int len, input logic [DATAW-1:0] d0, input logic [DATAW-1:0] dstep);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = d0 + DATAW'(j) * dstep;
            b.last = (j == len - 1);
            drv_q[r].push_back(b);
            mdl_q[r].push_back(b);
        end
    endtask

    // Whole packets go out in round-robin order among requesters holding a pending packet.
    task automatic build_expected();
        int    g;
        int    c;
        beat_t b;
        forever begin
            g = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (mdl_last + k) % NUM_REQ;
                if (g < 0 && mdl_q[c].size() > 0) g = c;
            end
            if (g < 0) break;
            mdl_last = g;
            do begin
                b = mdl_q[g].pop_front();
                exp_q.push_back(b);
            end while (!b.last);
        end
    endtask

    task automatic step();
        beat_t            b;
        bit               v;
        bit               hold_now;
        logic [NUM_REQ-1:0] pre_rdy, pre_vld;
        logic             pre_mv, pre_ml, pre_mr;
        logic [DATAW-1:0] pre_md;
        @(negedge clk);
        hold_now = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (drv_q[i].size() > 0) begin
                b = drv_q[i][0];
                v = 1;
                if (!first_beat[i]) begin
                    if (i == 0 && hold0 > 0) begin
                        v = 0;
                        hold0--;
                        hold_now = 1;
                    end else if (gap_en && $urandom_range(3) == 0) begin
                        v = 0;
                    end
                end
                s_tvalid[i] = v;
                s_tdata[i*DATAW +: DATAW] = b.data;
                s_tlast[i] = b.last;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tdata[i*DATAW +: DATAW] = $urandom;
                s_tlast[i] = 1'($urandom_range(1));
            end
        end
        m_tready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
        #2;
        pre_rdy = s_tready; pre_vld = s_tvalid;
        pre_mv = m_tvalid; pre_md = m_tdata; pre_ml = m_tlast; pre_mr = m_tready;
        check("one_ready", 64'($countones(s_tready) <= 1), 64'd1);
        if (hold_now) begin
            check("hold_grant", 64'(grant_id), 64'd0);
            check("hold_rdy3", 64'(s_tready[3]), 64'd0);
        end
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pre_vld[i] && pre_rdy[i]) begin
                if (first_beat[i] && gap_chk && last_tlast_cyc >= 0)
                    check("turnaround", 64'(cycle - last_tlast_cyc), 64'd2);
                b = drv_q[i].pop_front();
                first_beat[i] = b.last;
                if (b.last) last_tlast_cyc = cycle;
            end
        end
        if (pre_mv && pre_mr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(pre_md), 64'hdead);
            end else begin
                b = exp_q.pop_front();
                check("out_data", 64'(pre_md), 64'(b.data));
                check("out_last", 64'(pre_ml), 64'(b.last));
                out_sum += longint'(pre_md);
                if (b.last) begin
                    mdl_cnt++;
                    check("pkt_count", 64'(pkt_count), 64'(mdl_cnt[15:0]));
                    check("pkt_count_w2", 64'(pkt_count2), 64'(mdl_cnt[1:0]));
                end
            end
        end else if (pre_mv) begin
            check("stall_data", 64'(m_tdata), 64'(pre_md));
            check("stall_last", 64'(m_tlast), 64'(pre_ml));
        end
    endtask

    task automatic drain(input int budget);
        int  n;
        bit  pending;
        n = 0;
        forever begin
            pending = (exp_q.size() > 0);
            for (int i = 0; i < NUM_REQ; i++) if (drv_q[i].size() > 0) pending = 1;
            if (!pending) break;
            if (n >= budget) begin
                check("drain_timeout", 64'(exp_q.size()), 64'd0);
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_q[i].delete();
            mdl_q[i].delete();
            first_beat[i] = 1;
        end
        exp_q.delete();
        mdl_last = NUM_REQ - 1;
        mdl_cnt = 0;
    endtask

    task automatic check_reset_state();
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_tlast), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_pkt_count_w2", 64'(pkt_count2), 64'd0);
    endtask

    initial begin
        int n;
        clear_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;

        // All four requesters with single-beat packets at full throughput.
        gap_chk = 1;
        last_tlast_cyc = -1;
        add_pkt(0, 1, 10, 0); add_pkt(1, 1, 20, 0); add_pkt(2, 1, 30, 0); add_pkt(3, 1, 40, 0);
        build_expected();
        drain(100);
        step();
        check("pkt_count_4", 64'(pkt_count), 64'd4);
        gap_chk = 0;

        // Requester 1 alone, then req 2's 3-beat packet must finish before req 1 again.
        add_pkt(1, 1, 77, 0);
        build_expected();
        drain(50);
        add_pkt(2, 3, 5, 1);
        add_pkt(1, 2, 50, 1);
        build_expected();
        drain(100);

        // Random backpressure on a 4-beat packet.
        rdy_rand = 1;
        out_sum = 0;
        add_pkt(3, 4, 1, 1);
        build_expected();
        drain(200);
        check("sum_1_to_4", 64'(out_sum), 64'd10);
        rdy_rand = 0;

        // Mid-packet reset while a beat sits in the slice.
        add_pkt(1, 4, 32'h200, 1);
        build_expected();
        n = 0;
        while (!m_tvalid && n < 20) begin
            step();
            n++;
        end
        check("pre_rst_m_tvalid", 64'(m_tvalid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_s_tready", 64'(s_tready), 64'd0);
        check("midrst_pkt_count", 64'(pkt_count), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = '0;
        clear_model();
        add_pkt(2, 1, 32'h22, 0);
        add_pkt(0, 1, 32'h11, 0);
        build_expected();
        drain(50);

        // Granted requester 0 stalls mid-packet while requester 3 waits.
        add_pkt(0, 3, 32'h100, 1);
        add_pkt(3, 1, 32'h300, 0);
        build_expected();
        n = 0;
        while (first_beat[0] && n < 20) begin
            step();
            n++;
        end
        hold0 = 5;
        drain(100);
        check("hold_consumed", 64'(hold0), 64'd0);

        // Five packets from one requester: re-granted each time, narrow count wraps.
        for (int p = 0; p < 5; p++) begin
            add_pkt(2, 2, 32'(p * 16), 1);
            build_expected();
            drain(50);
        end

        // Randomized rounds with backpressure and mid-packet gaps.
        rdy_rand = 1;
        gap_en = 1;
        for (int r = 0; r < 8; r++) begin
            for (int q = 0; q < NUM_REQ; q++) begin
                n = $urandom_range(2);
                for (int p = 0; p < n; p++)
                    add_pkt(q, $urandom_range(1, 4), $urandom, $urandom);
            end
            build_expected();
            drain(600);
        end
        step();
        check("final_pkt_count", 64'(pkt_count), 64'(mdl_cnt[15:0]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
